// File: rtl/ftsd_scan_ctl_n.sv
// Self-timed N-digit 14-segment scan controller with per-frame data snapshot and blanking.
// Optional anti-ghosting dead time at the start of each slot when FTSD_DEADTIME_EN is defined.
module ftsd_scan_ctl_n #(
  parameter int                NUM_DIGITS  = 4,
  parameter int                DATA_W      = 5,
  parameter int                PRESCALE    = 50000,
  parameter logic [DATA_W-1:0] BLANK_CODE  = DATA_W'(5'h1F),
  parameter int                DEAD_CYCLES = 1,
  localparam int               IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NUM_DIGITS*DATA_W-1:0] din,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  output logic [DATA_W-1:0]            ftsd_in,
  output logic [NUM_DIGITS-1:0]        ftsd_ctl,
  output logic [IDX_W-1:0]             digit_idx,
  output logic                         frame_start
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

`ifdef FTSD_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS*DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]        mask_q, mask_d;
  logic [DATA_W-1:0]            ftsd_in_q, ftsd_in_d;
  logic [NUM_DIGITS-1:0]        ftsd_ctl_q, ftsd_ctl_d;
  logic [IDX_W-1:0]             digit_idx_q, digit_idx_d;
  logic                         frame_start_q, frame_start_d;

  logic                  tick;
  logic                  in_dead;
  logic [DATA_W-1:0]     sel_code;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] one_cold;

  always_comb begin
    tick      = en && (cnt_q == CNT_LAST);
    in_dead   = DEAD_EN && (cnt_q < CNT_W'(DEAD_CYCLES));
    sel_code  = shadow_q[int'(idx_q)*DATA_W +: DATA_W];
    sel_blank = mask_q[idx_q];
    one_cold  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) one_cold[NUM_DIGITS-1-i] = 1'b0;
    end

    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    ftsd_in_d     = '0;
    ftsd_ctl_d    = '1;
    digit_idx_d   = '0;
    frame_start_d = 1'b0;

    if (!en) begin
      // Display dark; shadow tracks inputs so a re-enable shows fresh data at once.
      cnt_d    = '0;
      idx_d    = '0;
      shadow_d = din;
      mask_d   = blank_mask;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (tick && (idx_q == IDX_LAST)) begin
        shadow_d = din;
        mask_d   = blank_mask;
      end
      digit_idx_d   = idx_q;
      frame_start_d = (idx_q == '0) && (cnt_q == '0);
      if (sel_blank) begin
        ftsd_in_d  = BLANK_CODE;
        ftsd_ctl_d = '1;
      end else begin
        ftsd_in_d  = sel_code;
        ftsd_ctl_d = in_dead ? '1 : one_cold;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      mask_q        <= '0;
      ftsd_in_q     <= '0;
      ftsd_ctl_q    <= '1;
      digit_idx_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      ftsd_in_q     <= ftsd_in_d;
      ftsd_ctl_q    <= ftsd_ctl_d;
      digit_idx_q   <= digit_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ftsd_in     = ftsd_in_q;
  assign ftsd_ctl    = ftsd_ctl_q;
  assign digit_idx   = digit_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ftsd_scan_ctl_n.sv
// Directed bench for ftsd_scan_ctl_n: 4 digits, 5-bit codes, PRESCALE=4.
module tb_ftsd_scan_ctl_n;

  localparam int ND = 4;
  localparam int DW = 5;
  localparam int PS = 4;
`ifdef FTSD_DEADTIME_EN
  localparam int DEAD = 1;
`else
  localparam int DEAD = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [ND*DW-1:0] din;
  logic [ND-1:0]    blank_mask;
  logic [DW-1:0]    ftsd_in;
  logic [ND-1:0]    ftsd_ctl;
  logic [1:0]       digit_idx;
  logic             frame_start;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [ND*DW-1:0] DATA_A = {5'd3, 5'd2, 5'd1, 5'd0};
  localparam logic [ND*DW-1:0] DATA_B = {5'd3, 5'd9, 5'd1, 5'd0};

  ftsd_scan_ctl_n #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .PRESCALE   (PS),
    .BLANK_CODE (5'h1F),
    .DEAD_CYCLES(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .blank_mask (blank_mask),
    .ftsd_in    (ftsd_in),
    .ftsd_ctl   (ftsd_ctl),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [ND-1:0] ectl, input logic [DW-1:0] ein,
                     input logic [1:0] eidx, input logic efs, input string tag);
    total_cnt++;
    assert (ftsd_ctl === ectl) pass_cnt++;
    else $error("FAIL %s ftsd_ctl observed=%b expected=%b", tag, ftsd_ctl, ectl);
    total_cnt++;
    assert (ftsd_in === ein) pass_cnt++;
    else $error("FAIL %s ftsd_in observed=%h expected=%h", tag, ftsd_in, ein);
    total_cnt++;
    assert (digit_idx === eidx) pass_cnt++;
    else $error("FAIL %s digit_idx observed=%0d expected=%0d", tag, digit_idx, eidx);
    total_cnt++;
    assert (frame_start === efs) pass_cnt++;
    else $error("FAIL %s frame_start observed=%b expected=%b", tag, frame_start, efs);
  endtask

  // Advance n cycles; c is the cycle number since the first enabled edge.
  task automatic run(input int c0, input int n, input logic [ND*DW-1:0] data,
                     input logic [ND-1:0] mask, input string tag);
    for (int c = c0; c < c0 + n; c++) begin
      int k;
      logic [ND-1:0] ectl;
      logic [DW-1:0] ein;
      @(posedge clk);
      @(negedge clk);
      k = (c / PS) % ND;
      if (mask[k]) begin
        ectl = 4'b1111;
        ein  = 5'h1F;
      end else begin
        ectl = ~(4'b1000 >> k);
        if ((c % PS) < DEAD) ectl = 4'b1111;
        ein = data[k*DW +: DW];
      end
      chk(ectl, ein, 2'(k), (c % (ND*PS)) == 0, $sformatf("%s c=%0d", tag, c));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    din        = DATA_A;
    blank_mask = '0;
    #12;
    chk(4'b1111, 5'd0, 2'd0, 1'b0, "reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    chk(4'b1111, 5'd0, 2'd0, 1'b0, "disabled_after_reset");

    en = 1'b1;
    run(0, 17, DATA_A, 4'b0000, "scan");

    run(17, 4, DATA_A, 4'b0000, "snap_pre");
    din = DATA_B;
    run(21, 11, DATA_A, 4'b0000, "snap_hold");
    run(32, 9, DATA_B, 4'b0000, "snap_new");

    blank_mask = 4'b0100;
    run(41, 7, DATA_B, 4'b0000, "blank_pending");
    run(48, 3, DATA_B, 4'b0100, "blank");
    blank_mask = 4'b0000;
    run(51, 13, DATA_B, 4'b0100, "blank_hold");
    run(64, 10, DATA_B, 4'b0000, "unblank");

    en  = 1'b0;
    din = DATA_A;
    @(posedge clk);
    @(negedge clk);
    chk(4'b1111, 5'd0, 2'd0, 1'b0, "disable_1");
    @(posedge clk);
    @(negedge clk);
    chk(4'b1111, 5'd0, 2'd0, 1'b0, "disable_2");

    en = 1'b1;
    run(0, 6, DATA_A, 4'b0000, "reenable");

    #2 rst_n = 1'b0;
    #1 chk(4'b1111, 5'd0, 2'd0, 1'b0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Shadow was cleared by reset, so the first frame after release shows zero codes.
    run(0, 5, '0, 4'b0000, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
